// File: rtl/testbasic18_sink.sv
// testbasic18 sink: sums write x, answers reads with the total. Writes take 1 cycle. A read holds the response until r_out_sync.
// A y=1 write withholds b_in_notify for HOLD_CYCLES cycles. Define TB18_SINK_SATURATE_EN to saturate the accumulator.
package testbasic18_pkg;
  typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic               y;
  } compound_t;
endpackage

module testbasic18_sink
  import testbasic18_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  compound_t          b_in,
  input  logic               b_in_sync,
  output logic               b_in_notify,
  output logic signed [31:0] r_out,
  input  logic               r_out_sync,
  output logic               r_out_notify,
  output compound_t          m_out,
  output logic [COUNT_W-1:0] cnt_out
);

  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {ST_RECV, ST_RESP, ST_HOLD} state_e;

  state_e             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] r_out_q, r_out_d;
  compound_t          m_out_q, m_out_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               b_in_xfer;
  logic               r_out_xfer;
  logic signed [32:0] sum_wide;
  logic signed [31:0] acc_sum;

  assign b_in_xfer  = b_in_sync  && (state_q == ST_RECV);
  assign r_out_xfer = r_out_sync && (state_q == ST_RESP);

  // Sign-extended add so bits [32:31] expose overflow in either direction.
  always_comb begin
    sum_wide = {acc_q[31], acc_q} + {b_in.x[31], b_in.x};
    acc_sum  = sum_wide[31:0];
`ifdef TB18_SINK_SATURATE_EN
    if (sum_wide[32:31] == 2'b01) begin
      acc_sum = 32'sh7FFF_FFFF;
    end else if (sum_wide[32:31] == 2'b10) begin
      acc_sum = 32'sh8000_0000;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    acc_d   = acc_q;
    r_out_d = r_out_q;
    m_out_d = m_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RECV: begin
        if (b_in_xfer) begin
          cnt_d = cnt_q + COUNT_W'(1);
          if (b_in.mode == MODE_WRITE) begin
            acc_d   = acc_sum;
            m_out_d = b_in;
            if (b_in.y && (HOLD_CYCLES != 0)) begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end else begin
            r_out_d = acc_q;
            if (b_in.y) begin
              acc_d = '0;
            end
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (r_out_xfer) begin
          state_d = ST_RECV;
        end
      end
      ST_HOLD: begin
        // Leaving at count 1 keeps notify low for exactly HOLD_CYCLES cycles.
        if (hold_q <= HW'(1)) begin
          state_d = ST_RECV;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RECV;
      hold_q  <= '0;
      acc_q   <= '0;
      r_out_q <= '0;
      m_out_q <= '{mode: MODE_READ, x: 32'sd0, y: 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      r_out_q <= r_out_d;
      m_out_q <= m_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign b_in_notify  = (state_q == ST_RECV);
  assign r_out_notify = (state_q == ST_RESP);
  assign r_out        = r_out_q;
  assign m_out        = m_out_q;
  assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_testbasic18_sink.sv
// Directed bench for testbasic18_sink: reset, accumulation, hold window, stalled read-and-clear, overflow, mid-response reset.
module tb_testbasic18_sink;
  import testbasic18_pkg::*;

  logic               clk;
  logic               rst;
  compound_t          b_in;
  logic               b_in_sync;
  logic               b_in_notify;
  logic signed [31:0] r_out;
  logic               r_out_sync;
  logic               r_out_notify;
  compound_t          m_out;
  logic [7:0]         cnt_out;

  int n_pass;
  int n_total;

  testbasic18_sink #(.HOLD_CYCLES(2), .COUNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .b_in         (b_in),
    .b_in_sync    (b_in_sync),
    .b_in_notify  (b_in_notify),
    .r_out        (r_out),
    .r_out_sync   (r_out_sync),
    .r_out_notify (r_out_notify),
    .m_out        (m_out),
    .cnt_out      (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic compound_t mk(input mode_e m, input logic signed [31:0] x, input logic y);
    compound_t c;
    c.mode = m;
    c.x    = x;
    c.y    = y;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a message and wait (bounded) for the accepting edge.
  task automatic put(input compound_t msg);
    b_in      = msg;
    b_in_sync = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (b_in_notify) begin
        tick();
        b_in_sync = 1'b0;
        return;
      end
      tick();
    end
    chk("put_timeout", 64'(b_in_notify), 64'd1);
    b_in_sync = 1'b0;
  endtask

  // Take one response (bounded) and compare its value.
  task automatic get(input string tag, input logic signed [31:0] exp);
    r_out_sync = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (r_out_notify) begin
        chk(tag, 64'(r_out), 64'(exp));
        tick();
        r_out_sync = 1'b0;
        return;
      end
      tick();
    end
    chk("get_timeout", 64'(r_out_notify), 64'd1);
    r_out_sync = 1'b0;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    b_in       = mk(MODE_READ, 32'sd0, 1'b0);
    b_in_sync  = 1'b0;
    r_out_sync = 1'b0;

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_b_in_notify", 64'(b_in_notify), 64'd1);
      chk("idle_r_out_notify", 64'(r_out_notify), 64'd0);
    end
    chk("idle_m_out", 64'(m_out), 64'(mk(MODE_READ, 32'sd0, 1'b0)));
    chk("idle_cnt", 64'(cnt_out), 64'd0);
    chk("idle_r_out", 64'(r_out), 64'd0);

    // Back-to-back writes 5, -2, 10 then read
    put(mk(MODE_WRITE, 32'sd5, 1'b0));
    chk("b2b_ready_after_w1", 64'(b_in_notify), 64'd1);
    chk("b2b_cnt_w1", 64'(cnt_out), 64'd1);
    put(mk(MODE_WRITE, -32'sd2, 1'b0));
    put(mk(MODE_WRITE, 32'sd10, 1'b0));
    put(mk(MODE_READ, 32'sd0, 1'b0));
    chk("rd1_notify", 64'(r_out_notify), 64'd1);
    chk("rd1_b_in_notify", 64'(b_in_notify), 64'd0);
    chk("rd1_value", 64'(r_out), 64'd13);
    chk("rd1_cnt", 64'(cnt_out), 64'd4);
    chk("rd1_m_out", 64'(m_out), 64'(mk(MODE_WRITE, 32'sd10, 1'b0)));
    get("rd1_xfer", 32'sd13);
    chk("rd1_ready_after", 64'(b_in_notify), 64'd1);
    chk("rd1_notify_after", 64'(r_out_notify), 64'd0);

    // Hold window: write x=1 y=1, next message held on b_in with sync high
    b_in      = mk(MODE_WRITE, 32'sd1, 1'b1);
    b_in_sync = 1'b1;
    tick();
    chk("hold_c1_notify", 64'(b_in_notify), 64'd0);
    chk("hold_c1_cnt", 64'(cnt_out), 64'd5);
    b_in = mk(MODE_WRITE, 32'sd3, 1'b0);
    tick();
    chk("hold_c2_notify", 64'(b_in_notify), 64'd0);
    chk("hold_c2_cnt", 64'(cnt_out), 64'd5);
    tick();
    chk("hold_c3_notify", 64'(b_in_notify), 64'd1);
    chk("hold_c3_cnt", 64'(cnt_out), 64'd5);
    tick();
    b_in_sync = 1'b0;
    chk("hold_next_cnt", 64'(cnt_out), 64'd6);
    chk("hold_next_m_out", 64'(m_out), 64'(mk(MODE_WRITE, 32'sd3, 1'b0)));

    // Read-and-clear stalled 5 cycles: total is 13 + 1 + 3
    put(mk(MODE_READ, 32'sd0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      chk("stall_r_out", 64'(r_out), 64'd17);
      chk("stall_b_in_notify", 64'(b_in_notify), 64'd0);
      chk("stall_r_out_notify", 64'(r_out_notify), 64'd1);
      tick();
    end
    get("rclr_xfer", 32'sd17);
    chk("rclr_m_out_kept", 64'(m_out), 64'(mk(MODE_WRITE, 32'sd3, 1'b0)));
    put(mk(MODE_READ, 32'sd0, 1'b0));
    get("rclr_second_read", 32'sd0);
    chk("rclr_cnt", 64'(cnt_out), 64'd8);

    // Overflow: 0x7FFFFFFF + 1
    put(mk(MODE_WRITE, 32'sh7FFF_FFFF, 1'b0));
    put(mk(MODE_WRITE, 32'sd1, 1'b0));
    put(mk(MODE_READ, 32'sd0, 1'b0));
`ifdef TB18_SINK_SATURATE_EN
    get("ovf_value", 32'sh7FFF_FFFF);
`else
    get("ovf_value", 32'sh8000_0000);
`endif
    chk("ovf_cnt", 64'(cnt_out), 64'd11);

    // Reset in the middle of a pending response
    put(mk(MODE_READ, 32'sd0, 1'b0));
    chk("mid_rst_pre_notify", 64'(r_out_notify), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_r_out_notify", 64'(r_out_notify), 64'd0);
    chk("mid_rst_b_in_notify", 64'(b_in_notify), 64'd1);
    chk("mid_rst_r_out", 64'(r_out), 64'd0);
    chk("mid_rst_cnt", 64'(cnt_out), 64'd0);
    chk("mid_rst_m_out", 64'(m_out), 64'(mk(MODE_READ, 32'sd0, 1'b0)));
    #2;
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(b_in_notify), 64'd1);
    put(mk(MODE_READ, 32'sd0, 1'b0));
    get("post_rst_read", 32'sd0);
    chk("post_rst_cnt", 64'(cnt_out), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
